// File: rtl/shadow_ret_checker_custom.sv
// ============================================================================
// shadow_ret_checker_custom : hardware shadow stack checking RET landing PCs
// Optional feature macro: SHADOW_RET_TVAL_EN (report expected address in tval)
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv;
  localparam int XLEN = 32;
  localparam int VLEN = 32;
  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 32'd2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;
endpackage

package shadow_ret_pkg;
  typedef enum logic [3:0] {ADD, JAL, JALR, BEQ} fu_op;

  typedef struct packed {
    logic [riscv::VLEN-1:0] pc;
    fu_op                   op;
    logic [5:0]             rs1;
    logic [5:0]             rs2;
    logic [5:0]             rd;
    logic                   is_compressed;
    riscv::exception_t      ex;
  } scoreboard_entry_t;
endpackage

module shadow_ret_checker_custom
  import shadow_ret_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              ack_i,
  input  scoreboard_entry_t entry_i,
  output scoreboard_entry_t entry_o,
  output logic              violation_o,
  output logic [CNT_W-1:0]  depth_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LANDING = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       top_q, top_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   viol_q, viol_d;
  logic [riscv::VLEN-1:0] stack_q [DEPTH];
  logic [riscv::VLEN-1:0] stack_d [DEPTH];

  logic                   hs;
  logic                   is_call;
  logic                   is_ret;
  logic                   landing;
  logic                   mismatch;
  logic                   pop;
  logic [riscv::VLEN-1:0] ret_addr;
  logic [riscv::VLEN-1:0] top_addr;
  logic [PTR_W-1:0]       top_inc;

  assign hs       = valid_i && ack_i;
  assign is_call  = !entry_i.ex.valid && (entry_i.op == JAL || entry_i.op == JALR)
                    && (entry_i.rd[4:0] == 5'd1 || entry_i.rd[4:0] == 5'd5);
  assign is_ret   = !entry_i.ex.valid && entry_i.op == JALR
                    && entry_i.rd[4:0] == 5'd0 && entry_i.rs1[4:0] == 5'd1;
  assign ret_addr = entry_i.pc + (entry_i.is_compressed ? riscv::VLEN'(2) : riscv::VLEN'(4));
  assign top_addr = stack_q[top_q];
  assign top_inc  = top_q + PTR_W'(1);
  assign landing  = (state_q == WAIT_LANDING);

  // A flushed landing is discarded, so it is neither checked nor marked.
  assign mismatch = valid_i && !flush_i && landing && !entry_i.ex.valid
                    && (cnt_q != '0) && (entry_i.pc != top_addr);
  assign pop      = landing && (cnt_q != '0);

  always_comb begin
    entry_o = entry_i;
    if (mismatch) begin
      entry_o.ex.valid = 1'b1;
      entry_o.ex.cause = riscv::ILLEGAL_INSTR;
`ifdef SHADOW_RET_TVAL_EN
      entry_o.ex.tval  = riscv::XLEN'(top_addr);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    stack_d = stack_q;
    viol_d  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hs) begin
      state_d = is_ret ? WAIT_LANDING : IDLE;
      viol_d  = mismatch;
      if (pop && is_call) begin
        // Pop-then-push collapses to replacing the top in place.
        stack_d[top_q] = ret_addr;
      end else if (pop) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else if (is_call) begin
        top_d            = top_inc;
        stack_d[top_inc] = ret_addr;
        if (cnt_q != C_FULL) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      top_q   <= '0;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      viol_q  <= viol_d;
      stack_q <= stack_d;
    end
  end

  assign depth_o     = cnt_q;
  assign violation_o = viol_q;

endmodule

`default_nettype wire

// File: tb/tb_shadow_ret_checker_custom.sv
// Directed testbench for shadow_ret_checker_custom (DEPTH = 8).
`default_nettype none

module tb_shadow_ret_checker_custom;
  import shadow_ret_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ack_i = 1'b0;
  scoreboard_entry_t entry_i;
  scoreboard_entry_t entry_o;
  logic              violation_o;
  logic [3:0]        depth_o;

  int errors = 0;
  int checks = 0;

  shadow_ret_checker_custom #(.DEPTH(8), .CNT_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ack_i       (ack_i),
    .entry_i     (entry_i),
    .entry_o     (entry_o),
    .violation_o (violation_o),
    .depth_o     (depth_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic scoreboard_entry_t mk(fu_op op, logic [5:0] rd, logic [5:0] rs1,
                                           logic [31:0] pc, logic c);
    scoreboard_entry_t e;
    e.pc            = pc;
    e.op            = op;
    e.rs1           = rs1;
    e.rs2           = 6'd0;
    e.rd            = rd;
    e.is_compressed = c;
    e.ex.cause      = 32'd0;
    e.ex.tval       = 32'd0;
    e.ex.valid      = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input scoreboard_entry_t e, input logic v, input logic a);
    entry_i = e;
    valid_i = v;
    ack_i   = a;
  endtask

  task automatic do_call(input logic [31:0] pc, input logic c);
    drive(mk(c ? JALR : JAL, 6'd1, c ? 6'd5 : 6'd0, pc, c), 1'b1, 1'b1);
    tick();
  endtask

  task automatic do_ret();
    drive(mk(JALR, 6'd0, 6'd1, 32'h8000_0400, 1'b0), 1'b1, 1'b1);
    tick();
  endtask

  task automatic go_idle();
    drive(mk(ADD, 6'd3, 6'd2, 32'h0, 1'b0), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    go_idle();
    tick();
    tick();
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth_o); end
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL reset_viol got=%b exp=0", violation_o); end
    checks++; if (entry_o !== entry_i) begin errors++; $display("FAIL reset_pass got=%h exp=%h", entry_o, entry_i); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_match();
    do_call(32'h8000_0100, 1'b0);
    checks++; if (depth_o !== 4'd1) begin errors++; $display("FAIL match_depth1 got=%0d exp=1", depth_o); end
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h8000_0104, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL match_exc got=%b exp=0", entry_o.ex.valid); end
    tick();
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL match_depth0 got=%0d exp=0", depth_o); end
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL match_viol got=%b exp=0", violation_o); end
    go_idle();
  endtask

  task automatic test_mismatch();
    scoreboard_entry_t e;
    logic [31:0] exp_tval;
`ifdef SHADOW_RET_TVAL_EN
    exp_tval = 32'h8000_0104;
`else
    exp_tval = 32'h0000_0055;
`endif
    do_call(32'h8000_0100, 1'b0);
    do_ret();
    e = mk(ADD, 6'd3, 6'd2, 32'h8000_0200, 1'b0);
    e.ex.tval = 32'h0000_0055;
    drive(e, 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b1) begin errors++; $display("FAIL mis_exc got=%b exp=1", entry_o.ex.valid); end
    checks++; if (entry_o.ex.cause !== 32'd2) begin errors++; $display("FAIL mis_cause got=%h exp=2", entry_o.ex.cause); end
    checks++; if (entry_o.ex.tval !== exp_tval) begin errors++; $display("FAIL mis_tval got=%h exp=%h", entry_o.ex.tval, exp_tval); end
    tick();
    checks++; if (violation_o !== 1'b1) begin errors++; $display("FAIL mis_viol got=%b exp=1", violation_o); end
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL mis_depth got=%0d exp=0", depth_o); end
    go_idle();
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL mis_viol_pulse got=%b exp=0", violation_o); end
  endtask

  task automatic test_compressed_empty();
    do_call(32'h8000_0010, 1'b1);
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h8000_0012, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL comp_exc got=%b exp=0", entry_o.ex.valid); end
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL comp_viol got=%b exp=0", violation_o); end
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h0000_1234, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL empty_exc got=%b exp=0", entry_o.ex.valid); end
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL empty_viol got=%b exp=0", violation_o); end
    go_idle();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      do_call(32'h8000_1000 + 32'(i * 4), 1'b0);
      checks++;
      if (depth_o !== ((i + 1 > 8) ? 4'd8 : 4'(i + 1))) begin
        errors++; $display("FAIL ovf_depth%0d got=%0d", i, depth_o);
      end
    end
    for (int j = 8; j >= 1; j--) begin
      do_ret();
      drive(mk(ADD, 6'd3, 6'd2, 32'h8000_1004 + 32'(j * 4), 1'b0), 1'b1, 1'b1);
      #1;
      checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL ovf_ret%0d got=%b exp=0", j, entry_o.ex.valid); end
      tick();
    end
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL ovf_empty got=%0d exp=0", depth_o); end
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL ovf_viol got=%b exp=0", violation_o); end
    go_idle();
  endtask

  task automatic test_landing_call();
    do_call(32'h8000_2000, 1'b0);
    do_call(32'h8000_3000, 1'b0);
    do_ret();
    drive(mk(JAL, 6'd1, 6'd0, 32'h8000_3004, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL lc_exc got=%b exp=0", entry_o.ex.valid); end
    tick();
    checks++; if (depth_o !== 4'd2) begin errors++; $display("FAIL lc_depth got=%0d exp=2", depth_o); end
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h8000_3008, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL lc_top got=%b exp=0", entry_o.ex.valid); end
    tick();
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h8000_2004, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL lc_bottom got=%b exp=0", entry_o.ex.valid); end
    tick();
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL lc_depth0 got=%0d exp=0", depth_o); end
    go_idle();
  endtask

  task automatic test_exc_passthrough();
    scoreboard_entry_t e;
    do_call(32'h8000_4000, 1'b0);
    do_ret();
    e = mk(ADD, 6'd3, 6'd2, 32'h0000_dead, 1'b0);
    e.ex.valid = 1'b1;
    e.ex.cause = 32'd7;
    e.ex.tval  = 32'h99;
    drive(e, 1'b1, 1'b1);
    #1;
    checks++; if (entry_o !== e) begin errors++; $display("FAIL exc_pass got=%h exp=%h", entry_o, e); end
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL exc_viol got=%b exp=0", violation_o); end
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL exc_pop got=%0d exp=0", depth_o); end
    e = mk(JAL, 6'd1, 6'd0, 32'h8000_5000, 1'b0);
    e.ex.valid = 1'b1;
    drive(e, 1'b1, 1'b1);
    tick();
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL exc_call got=%0d exp=0", depth_o); end
    go_idle();
  endtask

  task automatic test_flush();
    do_call(32'h8000_6000, 1'b0);
    do_ret();
    flush_i = 1'b1;
    drive(mk(ADD, 6'd3, 6'd2, 32'h0000_0bad, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL flush_exc got=%b exp=0", entry_o.ex.valid); end
    tick();
    flush_i = 1'b0;
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL flush_viol got=%b exp=0", violation_o); end
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL flush_depth got=%0d exp=0", depth_o); end
    do_call(32'h8000_7000, 1'b0);
    drive(mk(ADD, 6'd3, 6'd2, 32'h0000_0bad, 1'b0), 1'b1, 1'b1);
    #1;
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b exp=0", entry_o.ex.valid); end
    tick();
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h8000_7004, 1'b0), 1'b1, 1'b1);
    tick();
    go_idle();
  endtask

  task automatic test_stall();
    do_call(32'h8000_8000, 1'b0);
    do_ret();
    drive(mk(ADD, 6'd3, 6'd2, 32'h0000_0bad, 1'b0), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (entry_o.ex.valid !== 1'b1) begin errors++; $display("FAIL stall_mark%0d got=%b exp=1", k, entry_o.ex.valid); end
      tick();
      checks++; if (violation_o !== 1'b0 || depth_o !== 4'd1) begin
        errors++; $display("FAIL stall_hold%0d viol=%b depth=%0d exp viol=0 depth=1", k, violation_o, depth_o);
      end
    end
    ack_i = 1'b1;
    tick();
    checks++; if (violation_o !== 1'b1) begin errors++; $display("FAIL stall_viol got=%b exp=1", violation_o); end
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL stall_depth got=%0d exp=0", depth_o); end
    go_idle();
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL stall_pulse got=%b exp=0", violation_o); end
  endtask

  task automatic test_reset_mid();
    do_call(32'h8000_9000, 1'b0);
    do_call(32'h8000_9100, 1'b0);
    do_call(32'h8000_9200, 1'b0);
    do_ret();
    checks++; if (depth_o !== 4'd3) begin errors++; $display("FAIL rmid_pre got=%0d exp=3", depth_o); end
    drive(mk(ADD, 6'd3, 6'd2, 32'h0000_0bad, 1'b0), 1'b1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (depth_o !== 4'd0) begin errors++; $display("FAIL rmid_depth got=%0d exp=0", depth_o); end
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL rmid_viol got=%b exp=0", violation_o); end
    checks++; if (entry_o.ex.valid !== 1'b0) begin errors++; $display("FAIL rmid_exc got=%b exp=0", entry_o.ex.valid); end
    #1;
    rst_i = 1'b0;
    ack_i = 1'b1;
    tick();
    checks++; if (violation_o !== 1'b0) begin errors++; $display("FAIL rmid_land got=%b exp=0", violation_o); end
    go_idle();
  endtask

  initial begin
    entry_i = mk(ADD, 6'd0, 6'd0, 32'h0, 1'b0);
    test_reset();
    test_match();
    test_mismatch();
    test_compressed_empty();
    test_overflow();
    test_landing_call();
    test_exc_passthrough();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shadow_ret_checker_custom.md
# shadow_ret_checker_custom

- Sits directly downstream of the RET/landing-NOP parser on the decoded scoreboard-entry path, between decode and issue.
- Keeps a small hardware shadow stack of return addresses: pushed on every accepted call, checked and popped on the landing instruction that follows an accepted return.
- If the landing PC does not match the stack top, it turns the landing entry into an illegal-instruction exception.
- Entries already carrying an exception, including those raised by the upstream parser, pass through unchanged.

## Interface
Parameters:
- DEPTH, 8, shadow stack entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; clears pending state and the stack.
- valid_i  in  1  entry_i holds a decoded instruction.
- ack_i  in  1  issue accepts entry_o this cycle; handshake = valid_i && ack_i.
- entry_i  in  scoreboard_entry_t  entry from the upstream parser.
- entry_o  out  scoreboard_entry_t  entry to issue; possibly exception-marked.
- violation_o  out  1  one-cycle pulse, the cycle after a mismatching landing handshake.
- depth_o  out  CNT_W  current stack occupancy, 0..DEPTH.

## Operation
Instruction classes, all evaluated on entry_i with ex.valid==0:
- Call: op is JAL or JALR, and rd[4:0] is 1 or 5.
- Return: op is JALR, rd[4:0]==0, rs1[4:0]==1.
- Return address: pc + (is_compressed ? 2 : 4), VLEN-wide, wraps modulo 2^VLEN.

FSM states are IDLE and WAIT_LANDING.
- IDLE: an accepted Return moves to WAIT_LANDING; anything else stays in IDLE.
- WAIT_LANDING: the next accepted instruction is the landing instruction.
  - Landing entry with ex.valid==1: passes unchanged; stack is popped if non-empty; no violation.
  - Stack empty: no check; entry passes.
  - Otherwise: compare entry_i.pc with the stack top.
    - Mismatch: entry_o.ex.valid=1, entry_o.ex.cause=riscv::ILLEGAL_INSTR, violation_o pulses.
    - Either outcome: pop.
  - After the landing instruction, the next state is WAIT_LANDING if the landing instruction is itself a Return, otherwise IDLE.
- A landing instruction that is also a Call: pop first, then push its return address in the same cycle (top replaced, occupancy unchanged).
- Outside the landing case, entry_o = entry_i combinationally.

Stack:
- Circular buffer with top pointer and saturating occupancy count.
- Push when full overwrites the oldest entry; count stays at DEPTH.
- Pop when empty is a no-op.

Exceptions and flushes:
- An exception-marked entry is never treated as a Call or a Return.
- flush_i (has priority over any same-cycle handshake):
  - state goes to IDLE and occupancy to 0;
  - no push or pop is performed;
  - violation_o is not raised for that cycle's entry.

## Timing
- entry_o is combinational from entry_i and the registered state/stack, so the block adds zero latency.
- State, stack, count and violation_o update on the rising clock edge of a handshake cycle.
- violation_o is registered: high for exactly one cycle, the cycle after the offending handshake.
- Without a handshake (valid_i=0 or ack_i=0) nothing changes, and entry_o may still show the marking while the entry stalls.
- Reset values: state IDLE, depth_o 0, violation_o 0, stack contents 0. Reset takes effect immediately, even mid-check.

## Configuration
- SHADOW_RET_TVAL_EN defined: on a mismatch, entry_o.ex.tval is set to the expected return address (zero-extended to XLEN).
- Not defined: ex.tval is passed through unchanged from entry_i.
- Nothing else differs between the two builds.

## Test plan
- Matching return: Call JAL x1 at pc 0x8000_0100 (4-byte) then Return, then landing at 0x8000_0104.
  - Required: no exception, violation_o stays 0, depth_o goes 1 then 0.
- Mismatch: same sequence with landing at 0x8000_0200.
  - Required: entry_o.ex.valid=1 and cause=ILLEGAL_INSTR on that cycle, violation_o=1 on the next cycle only.
  - With the macro, tval=0x8000_0104.
- Compressed call and empty stack:
  - c.jalr call at 0x8000_0010 expects landing 0x8000_0012.
  - A Return with empty stack followed by any landing raises no violation.
- Overflow: 9 calls with DEPTH=8.
  - Required: depth_o saturates at 8.
  - Eight matching returns then pass; the first call's address is lost.
- Flush and stall:
  - flush_i in WAIT_LANDING with a concurrent handshake: no check, depth_o=0, state IDLE.
  - Landing held with ack_i=0 for 3 cycles: entry_o stays marked, violation_o pulses only once, after ack.
- Reset mid-operation: assert rst_i with depth_o=3 in WAIT_LANDING.
  - Required: depth_o=0 and violation_o=0 immediately.
  - A subsequent landing is not checked.
